// File: rtl/rsa_pkg.sv
// Shared types and helpers for the RSA core's Montgomery multiplier control.
package rsa_pkg;

   typedef enum logic [2:0] {
      IDLE, LOAD, MUL, RED, SHIFT, CHECK, SUB, DONE
   } mont_ctrl_state_t;

   function automatic int idx_w(input int data_width);
      return (data_width > 1) ? $clog2(data_width) : 1;
   endfunction

endpackage

// File: rtl/mont_mult_ctrl_if.sv
// Handshake/strobe bundle between the exponentiation sequencer (master) and
// the Montgomery controller (slave). abort exists only with MONT_MULT_CTRL_ABORT_EN.
interface mont_mult_ctrl_if import rsa_pkg::*; #(
   parameter int DATA_WIDTH = 8
) ();
   localparam int IW = idx_w(DATA_WIDTH);

   logic          start;
   logic [IW-1:0] t_sub_1;
   logic          geq;
`ifdef MONT_MULT_CTRL_ABORT_EN
   logic          abort;
`endif
   logic          busy;
   logic          done;
   logic          ld_op;
   logic          mul_en;
   logic          red_en;
   logic          red_first;
   logic          shift_en;
   logic          sub_en;
   logic [IW-1:0] i_idx;
   logic [IW-1:0] j_idx;

   modport master (
`ifdef MONT_MULT_CTRL_ABORT_EN
      output abort,
`endif
      output start, t_sub_1, geq,
      input  busy, done, ld_op, mul_en, red_en, red_first, shift_en, sub_en,
             i_idx, j_idx
   );

   modport slave (
`ifdef MONT_MULT_CTRL_ABORT_EN
      input  abort,
`endif
      input  start, t_sub_1, geq,
      output busy, done, ld_op, mul_en, red_en, red_first, shift_en, sub_en,
             i_idx, j_idx
   );
endinterface

// File: rtl/mont_mult_ctrl_counter.sv
// Inner word index counter; the controller decides when it wraps.
module counter_to_t_sub_1 #(
   parameter int IW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_i,
   input  logic          ce_i,
   input  logic          inc_i,
   input  logic          wrap_i,
   output logic [IW-1:0] cnt_o
);
   logic [IW-1:0] cnt_q;

   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || clr_i) begin
         cnt_q <= '0;
      end else if (ce_i) begin
         cnt_q <= wrap_i ? '0 : cnt_q + IW'(inc_i);
      end
   end

   assign cnt_o = cnt_q;
endmodule

// File: rtl/mont_mult_ctrl.sv
// Sequencing FSM for the word-serial Montgomery multiplier datapath.
// Optional abort input enabled by defining MONT_MULT_CTRL_ABORT_EN.
module mont_mult_ctrl import rsa_pkg::*; #(
   parameter int DATA_WIDTH = 8
) (
   input logic              clk,
   input logic              rst,
   mont_mult_ctrl_if.slave  ctrl_if
);
   localparam int IW = idx_w(DATA_WIDTH);

   mont_ctrl_state_t state_q, state_d;
   logic [IW-1:0]    i_q, i_d;
   logic [IW-1:0]    t_q, t_d;
   logic [IW-1:0]    j_cnt;
   logic             j_wrap;
   logic             abort_hit;

`ifdef MONT_MULT_CTRL_ABORT_EN
   assign abort_hit = ctrl_if.abort && (state_q != IDLE);
`else
   assign abort_hit = 1'b0;
`endif

   // Wrap at the latched length, never at the natural 2^IW rollover.
   assign j_wrap = (j_cnt == t_q);

   counter_to_t_sub_1 #(.IW(IW)) u_j_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (ctrl_if.ld_op || abort_hit),
      .ce_i   (ctrl_if.mul_en || ctrl_if.red_en),
      .inc_i  (1'b1),
      .wrap_i (j_wrap),
      .cnt_o  (j_cnt)
   );

   // NOTE: every variable gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      t_d     = t_q;
      unique case (state_q)
         IDLE: begin
            if (ctrl_if.start) begin
               state_d = LOAD;
               t_d     = ctrl_if.t_sub_1;
            end
         end
         LOAD: begin
            i_d     = '0;
            state_d = MUL;
         end
         MUL:   if (j_wrap) state_d = RED;
         RED:   if (j_wrap) state_d = SHIFT;
         SHIFT: begin
            if (i_q == t_q) begin
               i_d     = '0;
               state_d = CHECK;
            end else begin
               i_d     = i_q + IW'(1);
               state_d = MUL;
            end
         end
         CHECK: state_d = ctrl_if.geq ? SUB : DONE;
         SUB:   state_d = DONE;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (abort_hit) begin
         state_d = IDLE;
         i_d     = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         i_q     <= '0;
         t_q     <= '0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         t_q     <= t_d;
      end
   end

   // All outputs decode registered state and counters only.
   assign ctrl_if.busy      = (state_q != IDLE);
   assign ctrl_if.done      = (state_q == DONE);
   assign ctrl_if.ld_op     = (state_q == LOAD);
   assign ctrl_if.mul_en    = (state_q == MUL);
   assign ctrl_if.red_en    = (state_q == RED);
   assign ctrl_if.red_first = (state_q == RED) && (j_cnt == '0);
   assign ctrl_if.shift_en  = (state_q == SHIFT);
   assign ctrl_if.sub_en    = (state_q == SUB);
   assign ctrl_if.i_idx     = i_q;
   assign ctrl_if.j_idx     = j_cnt;
endmodule
